data_ram_responder: RTL and testbench

- Memory-side responder for the mem stage's data-memory interface: accepts one load/store request per access and returns read data.
- Inserts a configurable number of wait states and raises stallreq to freeze the pipeline until the access completes.
- Contains a word-organised data store with big-endian byte lanes: sel[3] = bits 31:24 = byte address offset 0.
- Sits between the mem stage and the top-level data bus; replaces an ideal zero-latency RAM model.

---
 rtl/data_ram_responder_pkg.sv | 22 ++
 rtl/data_ram_responder_if.sv | 23 ++
 rtl/data_ram_responder_bank.sv | 26 ++
 rtl/data_ram_responder.sv | 142 ++++++++++++++
 tb/tb_data_ram_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/data_ram_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, the zero word and the big-endian lane select patterns.
package data_ram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // sel[3] is byte offset 0 (bits 31:24)
  localparam logic [3:0] SEL_B0 = 4'b1000;
  localparam logic [3:0] SEL_B1 = 4'b0100;
  localparam logic [3:0] SEL_B2 = 4'b0010;
  localparam logic [3:0] SEL_B3 = 4'b0001;
  localparam logic [3:0] SEL_H0 = 4'b1100;
  localparam logic [3:0] SEL_H1 = 4'b0011;
  localparam logic [3:0] SEL_W  = 4'b1111;

endpackage

// File: rtl/data_ram_responder_if.sv
// Request/response bundle between the mem stage (master) and the data RAM responder (slave).
interface data_ram_responder_if;

  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        stallreq;

  modport slave (
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    output mem_data_o, mem_ack_o, stallreq
  );

  modport master (
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    input  mem_data_o, mem_ack_o, stallreq
  );

endinterface

// File: rtl/data_ram_responder_bank.sv
// Word-organised data store: synchronous byte-enable write, asynchronous read.
// Contents are deliberately not reset.
module data_ram_bank #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [3:0]        i_sel,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we && i_sel[i]) begin
        r_mem[i_idx][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_ram_responder.sv
// Data-memory responder: inserts LATENCY wait states per access, stalling the pipeline
// until a one-cycle ack, and serves loads/stores from a byte-lane data bank.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_ram_responder_if.slave bus
);

  localparam logic [3:0] LatCnt = 4'(LATENCY - 1);

  state_t            r_state, w_nextState;
  logic [3:0]        r_cnt, w_nextCnt;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  logic [ADDR_W-1:0] w_reqIdx;
  logic              w_capture;
  logic              w_latchRead;
  logic              w_bankWe;
  logic [3:0]        w_bankSel;
  logic [ADDR_W-1:0] w_bankIdx;
  logic [31:0]       w_bankWdata;
  logic [31:0]       w_bankRdata;
  logic              w_stall;
  logic              w_ack;
  logic [31:0]       w_dataOut;
  logic              w_unused;

  assign w_reqIdx = bus.mem_addr_i[ADDR_W+1:2];
  assign w_unused = ^{bus.mem_addr_i[31:ADDR_W+2], bus.mem_addr_i[1:0]};

  // The capture cycle counts as the first wait state, so WAIT lasts LATENCY-1 cycles.
  // Outputs are forced quiet while reset is asserted so an abort is visible at once.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_capture   = 1'b0;
    w_latchRead = 1'b0;
    w_bankWe    = 1'b0;
    w_bankSel   = r_sel;
    w_bankWdata = r_wdata;
    w_bankIdx   = r_idx;
    w_stall     = 1'b0;
    w_ack       = 1'b0;
    w_dataOut   = r_rdata;
    if (rst) begin
      case (r_state)
        IDLE: begin
          w_bankIdx = w_reqIdx;
          if (bus.mem_ce_i) begin
            if (LATENCY == 0) begin
              w_ack       = 1'b1;
              w_bankWe    = bus.mem_we_i;
              w_bankSel   = bus.mem_sel_i;
              w_bankWdata = bus.mem_data_i;
              if (!bus.mem_we_i) begin
                w_latchRead = 1'b1;
                w_dataOut   = w_bankRdata;
              end
            end else begin
              w_stall   = 1'b1;
              w_capture = 1'b1;
              w_nextCnt = LatCnt;
              if (LATENCY == 1) begin
                w_nextState = DONE;
                w_latchRead = !bus.mem_we_i;
              end else begin
                w_nextState = WAIT;
              end
            end
          end
        end
        WAIT: begin
          w_stall = 1'b1;
          if (r_cnt <= 4'd1) begin
            w_nextState = DONE;
            w_latchRead = !r_we;
          end else begin
            w_nextCnt = r_cnt - 4'd1;
          end
        end
        DONE: begin
          w_ack       = 1'b1;
          w_bankWe    = r_we;
          w_nextState = IDLE;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_sel   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= ZeroWord;
      r_rdata <= ZeroWord;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_capture) begin
        r_we    <= bus.mem_we_i;
        r_sel   <= bus.mem_sel_i;
        r_idx   <= w_reqIdx;
        r_wdata <= bus.mem_data_i;
      end
      if (w_latchRead) begin
        r_rdata <= w_bankRdata;
      end
    end
  end

  data_ram_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk     (clk),
    .i_we    (w_bankWe),
    .i_sel   (w_bankSel),
    .i_idx   (w_bankIdx),
    .i_wdata (w_bankWdata),
    .o_rdata (w_bankRdata)
  );

  assign bus.mem_data_o = w_dataOut;
  assign bus.mem_ack_o  = w_ack;
  assign bus.stallreq   = w_stall;

  // The mem stage must hold the request while the access is pending
  a_requestStable: assert property (@(posedge clk) disable iff (!rst)
    (r_state == WAIT) |-> $stable({bus.mem_we_i, bus.mem_sel_i, w_reqIdx, bus.mem_data_i}))
    else $warning("data_ram_responder: request inputs changed while access pending");

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder: one instance with LATENCY=2, one with LATENCY=0.
module tb_data_ram_responder;
  import data_ram_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_ram_responder_if bus2();
  data_ram_responder_if bus0();

  data_ram_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  data_ram_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    bit          isLoad;
    logic [31:0] data;
    int          stalls;
  } exp_t;

  exp_t        q2[$];
  exp_t        q0[$];
  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] lastLoad2  = 32'h0;
  logic [31:0] lastLoad0  = 32'h0;
  int          stallRun2  = 0;
  int          stallRun0  = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
  endtask

  // Monitors: pop one expectation per ack; stores must leave mem_data_o at the last load value
  always @(negedge clk) begin
    exp_t e;
    if (!rst) stallRun2 = 0;
    else begin
      if (bus2.stallreq) stallRun2++;
      if (bus2.mem_ack_o) begin
        if (q2.size() == 0) checkOutput("dut2 spurious ack", 32'(q2.size()), 32'd1);
        else begin
          e = q2.pop_front();
          checkOutput(e.isLoad ? "dut2 load data" : "dut2 data hold", bus2.mem_data_o, e.data);
          checkOutput("dut2 stall cycles", 32'(stallRun2), 32'(e.stalls));
        end
        stallRun2 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) stallRun0 = 0;
    else begin
      if (bus0.stallreq) stallRun0++;
      if (bus0.mem_ack_o) begin
        if (q0.size() == 0) checkOutput("dut0 spurious ack", 32'(q0.size()), 32'd1);
        else begin
          e = q0.pop_front();
          checkOutput(e.isLoad ? "dut0 load data" : "dut0 data hold", bus0.mem_data_o, e.data);
          checkOutput("dut0 stall cycles", 32'(stallRun0), 32'(e.stalls));
        end
        stallRun0 = 0;
      end
    end
  end

  task automatic applyStimulus2(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] want,
                                input bit moveAddr);
    exp_t e;
    int   cycles;
    e.isLoad = !we;
    e.data   = we ? lastLoad2 : want;
    e.stalls = 2;
    if (!we) lastLoad2 = want;
    q2.push_back(e);
    bus2.mem_ce_i   = 1'b1;
    bus2.mem_we_i   = we;
    bus2.mem_sel_i  = sel;
    bus2.mem_addr_i = addr;
    bus2.mem_data_i = data;
    @(negedge clk);
    cycles = 1;
    if (moveAddr) begin
      @(posedge clk);
      #1 bus2.mem_addr_i = addr ^ 32'h4;
      @(negedge clk);
      cycles++;
    end
    while (!bus2.mem_ack_o && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("dut2 ack within bound", 32'(bus2.mem_ack_o), 32'd1);
    @(posedge clk);
    #1 bus2.mem_ce_i = 1'b0;
  endtask

  task automatic applyStimulus0(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] want);
    exp_t e;
    e.isLoad = !we;
    e.data   = we ? lastLoad0 : want;
    e.stalls = 0;
    if (!we) lastLoad0 = want;
    q0.push_back(e);
    bus0.mem_ce_i   = 1'b1;
    bus0.mem_we_i   = we;
    bus0.mem_sel_i  = sel;
    bus0.mem_addr_i = addr;
    bus0.mem_data_i = data;
    @(negedge clk);
    checkOutput("dut0 ack same cycle", 32'(bus0.mem_ack_o), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus2.mem_ce_i = 1'b0; bus2.mem_we_i = 1'b0; bus2.mem_sel_i = 4'd0;
    bus2.mem_addr_i = 32'h0; bus2.mem_data_i = 32'h0;
    bus0.mem_ce_i = 1'b0; bus0.mem_we_i = 1'b0; bus0.mem_sel_i = 4'd0;
    bus0.mem_addr_i = 32'h0; bus0.mem_data_i = 32'h0;

    #12;
    checkOutput("reset stallreq", 32'(bus2.stallreq), 32'd0);
    checkOutput("reset ack", 32'(bus2.mem_ack_o), 32'd0);
    checkOutput("reset data", bus2.mem_data_o, 32'h0);
    checkOutput("reset dut0 data", bus0.mem_data_o, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    applyStimulus2(1'b1, SEL_W, 32'h14, 32'h5555_5555, 32'h0, 1'b0);
    applyStimulus2(1'b0, SEL_W, 32'h14, 32'h0, 32'h5555_5555, 1'b0);

    // Store to word 5 aborted by reset in WAIT: no ack, no write
    bus2.mem_ce_i = 1'b1; bus2.mem_we_i = 1'b1; bus2.mem_sel_i = SEL_W;
    bus2.mem_addr_i = 32'h14; bus2.mem_data_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort stallreq", 32'(bus2.stallreq), 32'd0);
    checkOutput("abort ack", 32'(bus2.mem_ack_o), 32'd0);
    checkOutput("abort data cleared", bus2.mem_data_o, 32'h0);
    bus2.mem_ce_i = 1'b0;
    lastLoad2 = 32'h0;
    @(posedge clk);
    #1 rst = 1'b1;

    applyStimulus2(1'b0, SEL_W, 32'h14, 32'h0, 32'h5555_5555, 1'b0);
    applyStimulus2(1'b1, SEL_W, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
    applyStimulus2(1'b0, SEL_W, 32'h10, 32'h0, 32'h1234_5678, 1'b0);
    applyStimulus2(1'b1, SEL_B1, 32'h11, 32'hAAAA_AAAA, 32'h0, 1'b0);
    applyStimulus2(1'b0, SEL_W, 32'h10, 32'h0, 32'h12AA_5678, 1'b0);
    applyStimulus2(1'b1, SEL_H1, 32'h12, 32'hBEEF_BEEF, 32'h0, 1'b0);
    applyStimulus2(1'b0, SEL_W, 32'h10, 32'h0, 32'h12AA_BEEF, 1'b0);
    applyStimulus2(1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0);
    applyStimulus2(1'b0, SEL_W, 32'h10, 32'h0, 32'h12AA_BEEF, 1'b0);
    applyStimulus2(1'b1, SEL_W, 32'h1000, 32'hCAFE_F00D, 32'h0, 1'b0);
    applyStimulus2(1'b0, SEL_W, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
    applyStimulus2(1'b1, SEL_W, 32'h24, 32'h1111_1111, 32'h0, 1'b0);
    applyStimulus2(1'b1, SEL_W, 32'h20, 32'h0BAD_C0DE, 32'h0, 1'b1);
    applyStimulus2(1'b0, SEL_W, 32'h20, 32'h0, 32'h0BAD_C0DE, 1'b0);
    applyStimulus2(1'b0, SEL_W, 32'h24, 32'h0, 32'h1111_1111, 1'b0);

    // Zero-latency instance: one access per cycle, alternating store/load
    applyStimulus0(1'b1, SEL_W, 32'h8, 32'h0102_0304, 32'h0);
    applyStimulus0(1'b0, SEL_W, 32'h8, 32'h0, 32'h0102_0304);
    applyStimulus0(1'b1, SEL_B3, 32'hB, 32'h0000_00FF, 32'h0);
    applyStimulus0(1'b0, SEL_W, 32'h8, 32'h0, 32'h0102_03FF);
    applyStimulus0(1'b1, SEL_W, 32'hC, 32'h0F0F_0F0F, 32'h0);
    applyStimulus0(1'b0, SEL_W, 32'hC, 32'h0, 32'h0F0F_0F0F);
    bus0.mem_ce_i = 1'b0;

    repeat (4) @(posedge clk);
    checkOutput("dut2 queue drained", 32'(q2.size()), 32'd0);
    checkOutput("dut0 queue drained", 32'(q0.size()), 32'd0);
    checkOutput("dut0 idle ack", 32'(bus0.mem_ack_o), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
